// File: rtl/lc3_mem_arbiter_if.sv
`default_nettype none
// =============================================================================
// lc3_mem_arbiter_if : fetch, memaccess and shared-memory signal bundle for
//                      lc3_mem_arbiter (master = requesters + memory, slave = arbiter).
// Revision: 1.0
// =============================================================================
interface lc3_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] m_rdata;

    logic              owner;
    logic              busy;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        input  i_gnt, i_rdata, i_rvalid, d_gnt, d_rdata, d_rvalid,
               m_req, m_we, m_addr, m_wdata, owner, busy
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
        output i_gnt, i_rdata, i_rvalid, d_gnt, d_rdata, d_rvalid,
               m_req, m_we, m_addr, m_wdata, owner, busy
    );
endinterface
`default_nettype wire

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// =============================================================================
// lc3_mem_arbiter : serialises LC3 fetch and memaccess onto one variable-latency
//                   memory port, dmem first. Optional LC3_ARB_STARVE_GUARD_EN
//                   forces an imem grant after STARVE_MAX back-to-back dmem wins.
// Revision: 1.0
// =============================================================================
module lc3_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    lc3_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_IACC = 2'd1,
        S_DACC = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              i_gnt_q, i_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              imem_forced;
    logic              imem_win;

`ifdef LC3_ARB_STARVE_GUARD_EN
    localparam int               CNT_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_q, starve_d;

    assign imem_forced = (starve_q == CNT_MAX);

    // Counts dmem wins taken while fetch was also asking; saturates at CNT_MAX.
    always_comb begin
        starve_d = starve_q;
        if (state_q == S_IDLE) begin
            if (!bus.i_req || imem_win) begin
                starve_d = '0;
            end else if (bus.d_req && (starve_q != CNT_MAX)) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict dmem priority; the comparison keeps STARVE_MAX referenced and is 0 for legal values.
    assign imem_forced = (STARVE_MAX < 0);
`endif

    assign imem_win = bus.i_req && (imem_forced || !bus.d_req);

    always_comb begin
        state_d    = state_q;
        i_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (imem_win) begin
                    state_d   = S_IACC;
                    i_gnt_d   = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = bus.i_addr;
                    m_wdata_d = '0;
                    owner_d   = 1'b0;
                    busy_d    = 1'b1;
                end else if (bus.d_req) begin
                    state_d   = S_DACC;
                    d_gnt_d   = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    owner_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_IACC, S_DACC: begin
                if (m_req_q && bus.m_ack) begin
                    state_d = S_IDLE;
                    m_req_d = 1'b0;
                    busy_d  = 1'b0;
                    if (state_q == S_IACC) begin
                        i_rdata_d  = bus.m_rdata;
                        i_rvalid_d = 1'b1;
                    end else begin
                        d_rvalid_d = 1'b1;
                        // A write completion leaves the last read value visible.
                        if (!m_we_q) begin
                            d_rdata_d = bus.m_rdata;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_gnt_q    <= i_gnt_d;
            d_gnt_q    <= d_gnt_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.i_gnt    = i_gnt_q;
    assign bus.d_gnt    = d_gnt_q;
    assign bus.i_rvalid = i_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.m_req    = m_req_q;
    assign bus.m_we     = m_we_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.owner    = owner_q;
    assign bus.busy     = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// =============================================================================
// tb_lc3_mem_arbiter : scoreboard bench for lc3_mem_arbiter with a wait-state
//                      memory model; grant order depends on LC3_ARB_STARVE_GUARD_EN.
// Revision: 1.0
// =============================================================================
module tb_lc3_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lc3_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lc3_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic              own;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    logic              gnt_log[$];
    logic [DATA_W-1:0] mem_arr[logic [ADDR_W-1:0]];
    int                checks = 0;
    int                errors = 0;
    int                mem_wait = 1;
    int                wcnt = 0;
    bit                mem_auto = 1'b1;
    logic              force_ack = 1'b0;
    logic [DATA_W-1:0] force_rdata = '0;
    logic [DATA_W-1:0] exp_i_rdata = '0;
    logic [DATA_W-1:0] exp_d_rdata = '0;

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 16'hA5A5;
    endfunction

    // Memory model: acks after mem_wait cycles of m_req, or replays forced values.
    initial begin : mem_model
        bus.m_ack   = 1'b0;
        bus.m_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            if (!mem_auto) begin
                bus.m_ack   = force_ack;
                bus.m_rdata = force_rdata;
            end else if (bus.m_req === 1'b1) begin
                if (wcnt >= mem_wait) begin
                    bus.m_ack = 1'b1;
                    if (bus.m_we) begin
                        mem_arr[bus.m_addr] = bus.m_wdata;
                        bus.m_rdata = 16'hDEAD;
                    end else begin
                        bus.m_rdata = mem_rd(bus.m_addr);
                    end
                end else begin
                    bus.m_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.m_ack = 1'b0;
                wcnt      = 0;
            end
        end
    end

    // Grant logger and completion scoreboard.
    initial begin : monitor
        forever begin
            @(posedge clock);
            #1;
            if (bus.i_gnt === 1'b1) gnt_log.push_back(1'b0);
            if (bus.d_gnt === 1'b1) gnt_log.push_back(1'b1);
            if (bus.i_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
                checks++;
                if (bus.i_rvalid === 1'b1 && bus.d_rvalid === 1'b1) begin
                    errors++;
                    $display("FAIL rvalid_both: got i_rvalid=1 d_rvalid=1 required one");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: got i_rvalid=%b d_rvalid=%b required none",
                             bus.i_rvalid, bus.d_rvalid);
                end else begin
                    mon_e = sb.pop_front();
                    if (bus.d_rvalid !== mon_e.own ||
                        (mon_e.own ? bus.d_rdata : bus.i_rdata) !== mon_e.data) begin
                        errors++;
                        $display("FAIL rvalid_data: got owner=%b data=%h required owner=%b data=%h",
                                 bus.d_rvalid, mon_e.own ? bus.d_rdata : bus.i_rdata,
                                 mon_e.own, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clock);
        while ((bus.busy !== 1'b0 || bus.m_req !== 1'b0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_idle: got busy=%b required 0", name, bus.busy);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d outstanding required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({bus.m_req, bus.busy, bus.owner} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got m_req/busy/owner=%b required 000",
                     {bus.m_req, bus.busy, bus.owner});
        end
        checks++;
        if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b required 0000",
                     {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid});
        end
        checks++;
        if (bus.i_rdata !== 16'h0 || bus.d_rdata !== 16'h0 || bus.m_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got i_rdata=%h d_rdata=%h m_addr=%h required 0",
                     bus.i_rdata, bus.d_rdata, bus.m_addr);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || gnt_log.size() != 0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b grants=%0d required 0/0", bus.busy, gnt_log.size());
        end
    endtask

    task automatic test_fetch();
        mem_arr[16'h3000] = 16'h1221;
        mem_wait = 1;
        sb.push_back('{own: 1'b0, data: 16'h1221});
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h3000;
        @(negedge clock);
        checks++;
        if ({bus.i_gnt, bus.m_req, bus.m_we, bus.owner, bus.busy} !== 5'b11001 ||
            bus.m_addr !== 16'h3000) begin
            errors++;
            $display("FAIL fetch_grant: got gnt/req/we/owner/busy=%b m_addr=%h required 11001 3000",
                     {bus.i_gnt, bus.m_req, bus.m_we, bus.owner, bus.busy}, bus.m_addr);
        end
        bus.i_req = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.busy !== 1'b0 || bus.i_rdata !== 16'h1221) begin
            errors++;
            $display("FAIL fetch_done: got i_rvalid=%b busy=%b i_rdata=%h required 1 0 1221",
                     bus.i_rvalid, bus.busy, bus.i_rdata);
        end
        exp_i_rdata = 16'h1221;
        wait_idle("fetch");
    endtask

    task automatic test_write();
        mem_wait = 3;
        sb.push_back('{own: 1'b1, data: exp_d_rdata});
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h4000; bus.d_wdata = 16'hBEEF;
        @(negedge clock);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL write_grant: got d_gnt=%b i_gnt=%b required 1 0", bus.d_gnt, bus.i_gnt);
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({bus.m_req, bus.m_we} !== 2'b11 || bus.m_wdata !== 16'hBEEF ||
                bus.m_addr !== 16'h4000) begin
                errors++;
                $display("FAIL write_hold%0d: got req/we=%b wdata=%h addr=%h required 11 BEEF 4000",
                         k, {bus.m_req, bus.m_we}, bus.m_wdata, bus.m_addr);
            end
            @(negedge clock);
        end
        checks++;
        if (bus.m_req !== 1'b0 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL write_done: got m_req=%b d_rvalid=%b d_rdata=%h required 0 1 %h",
                     bus.m_req, bus.d_rvalid, bus.d_rdata, exp_d_rdata);
        end
        wait_idle("write");
    endtask

    task automatic test_simultaneous();
        int n = 0;
        mem_arr[16'h4001] = 16'h0005;
        mem_arr[16'h3002] = 16'h5A5A;
        mem_wait = 1;
        sb.push_back('{own: 1'b1, data: 16'h0005});
        sb.push_back('{own: 1'b0, data: 16'h5A5A});
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h4001;
        bus.i_req = 1'b1; bus.i_addr = 16'h3002;
        @(negedge clock);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL simul_first: got d_gnt=%b i_gnt=%b required 1 0", bus.d_gnt, bus.i_gnt);
        end
        bus.d_req = 1'b0;
        while (bus.i_gnt !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.m_addr !== 16'h3002) begin
            errors++;
            $display("FAIL simul_second: got i_gnt=%b m_addr=%h required 1 3002", bus.i_gnt, bus.m_addr);
        end
        bus.i_req = 1'b0;
        exp_d_rdata = 16'h0005;
        exp_i_rdata = 16'h5A5A;
        wait_idle("simul");
    endtask

    task automatic test_reset_mid();
        mem_wait = 20;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h4002;
        @(negedge clock);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.m_req !== 1'b1 || bus.owner !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got m_req=%b owner=%b required 1 1", bus.m_req, bus.owner);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.m_req, bus.busy, bus.owner, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 7'b0) begin
            errors++;
            $display("FAIL rstmid_async: got %b required 0000000",
                     {bus.m_req, bus.busy, bus.owner, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid});
        end
        @(negedge clock);
        reset = 1'b0;
        mem_wait = 1;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        repeat (4) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.d_rdata !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_after: got busy=%b d_rdata=%h required 0 0000", bus.busy, bus.d_rdata);
        end
        sb.push_back('{own: 1'b0, data: 16'h1221});
        bus.i_req = 1'b1; bus.i_addr = 16'h3000;
        @(negedge clock);
        checks++;
        if (bus.i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle: got i_gnt=%b required 1", bus.i_gnt);
        end
        bus.i_req = 1'b0;
        exp_i_rdata = 16'h1221;
        wait_idle("rstmid");
    endtask

    task automatic test_spurious();
        gnt_log.delete();
        mem_auto = 1'b0; force_ack = 1'b1; force_rdata = 16'hFFFF;
        repeat (3) @(negedge clock);
        force_ack = 1'b0;
        @(negedge clock);
        mem_auto = 1'b1;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL spur_ack: got busy=%b i_rdata=%h d_rdata=%h required 0 %h %h",
                     bus.busy, bus.i_rdata, bus.d_rdata, exp_i_rdata, exp_d_rdata);
        end
        mem_wait = 4;
        sb.push_back('{own: 1'b1, data: 16'h0005});
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h4001;
        @(negedge clock);
        bus.d_req = 1'b0;
        @(negedge clock);
        bus.i_req = 1'b1; bus.i_addr = 16'h3004;
        @(negedge clock);
        bus.i_req = 1'b0;
        exp_d_rdata = 16'h0005;
        wait_idle("spur");
        checks++;
        if (gnt_log.size() != 1 || gnt_log[0] !== 1'b1) begin
            errors++;
            $display("FAIL spur_grants: got %0d grants required exactly one dmem grant", gnt_log.size());
        end
        mem_wait = 1;
    endtask

    task automatic test_back_to_back();
        int   n = 0;
        logic exp_own;
        gnt_log.delete();
        mem_wait = 0;
        for (int k = 0; k < 10; k++) begin
`ifdef LC3_ARB_STARVE_GUARD_EN
            exp_own = (k % 5 == 4) ? 1'b0 : 1'b1;
`else
            exp_own = 1'b1;
`endif
            sb.push_back('{own: exp_own, data: exp_own ? 16'hBEEF : 16'h1221});
        end
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h4000;
        bus.i_req = 1'b1; bus.i_addr = 16'h3000;
        while (gnt_log.size() < 10 && n < 200) begin
            @(negedge clock);
            n++;
        end
        bus.d_req = 1'b0;
        bus.i_req = 1'b0;
        wait_idle("b2b");
        checks++;
        if (gnt_log.size() != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants required 10", gnt_log.size());
        end
        for (int k = 0; k < 10 && k < gnt_log.size(); k++) begin
`ifdef LC3_ARB_STARVE_GUARD_EN
            exp_own = (k % 5 == 4) ? 1'b0 : 1'b1;
`else
            exp_own = 1'b1;
`endif
            checks++;
            if (gnt_log[k] !== exp_own) begin
                errors++;
                $display("FAIL b2b_order%0d: got owner=%b required %b", k, gnt_log[k], exp_own);
            end
        end
        mem_wait = 1;
    endtask

    initial begin : main
        test_reset();
        test_fetch();
        test_write();
        test_simultaneous();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
